pipeline_stall_ctrl: RTL
========================

// Module: pipeline_stall_ctrl
// PURPOSE
// - Consumer of the load-use lock and the other pipeline hazard requests.
//   Turns them into PC / IF-ID / ID-EX control for the 5-stage MIPS pipeline.
// - Arbitrates three sources: syscall halt, EX-stage branch flush and ID load-use stall.
// - Runs a 4-state FSM and enforces a multi-cycle flush window.
// - Watchdogs runaway stalls.
// PARAMETERS
// - FLUSH_CYCLES  default 1  cycles of IF/ID flush + ID/EX bubble per taken branch (legal 1..15)
// - MAX_STALL     default 4  consecutive STALL cycles that set stall_timeout (legal 1..255)
// PORTS
// - clk             in   1   system clock; all state updates on posedge
// - rst_n           in   1   asynchronous, active-low reset
// - nop_lock_id     in   1   load-use stall request for the instruction in ID
// - branch_taken_ex in   1   taken branch/jump resolved in EX; flush request
// - syscall_halt_id in   1   halting syscall decoded in ID
// - resume          in   1   single-cycle pulse releasing HALT
// - pc_en           out  1   PC register write enable
// - ifid_en         out  1   IF/ID register write enable
// - ifid_flush      out  1   IF/ID register clear to NOP
// - idex_bubble     out  1   ID/EX control fields cleared (bubble inserted)
// - halted          out  1   FSM is in HALT
// - stall_timeout   out  1   sticky watchdog error
// - state_o         out  2   current state: RUN=0 STALL=1 FLUSH=2 HALT=3
// BEHAVIOUR
// - Reset (rst_n=0, async):
//   - state=RUN, flush counter=0, consecutive-stall counter=0, stall_timeout=0.
//   - Outputs forced: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1, halted=0.
// - next_state is combinational; first matching rule wins.
//   - In HALT: resume=1 -> RUN; otherwise stay HALT. All other requests are ignored.
//   - syscall_halt_id=1 -> HALT. Beats branch and stall in the same cycle.
//   - branch_taken_ex=1 -> FLUSH; flush counter loads FLUSH_CYCLES-1.
//     - A branch while already in FLUSH reloads the counter.
//   - In FLUSH with counter != 0 -> stay FLUSH and decrement.
//     - nop_lock_id is ignored here: the locked instruction is being flushed.
//   - nop_lock_id=1 -> STALL.
//   - Otherwise -> RUN.
// - Outputs are Mealy, decoded from next_state in the same cycle as the request (0 latency).
//   State register <= next_state at posedge.
//
//   | next_state | pc_en | ifid_en | ifid_flush | idex_bubble | halted |
//   |------------|-------|---------|------------|-------------|--------|
//   | RUN        | 1     | 1       | 0          | 0           | 0      |
//   | STALL      | 0     | 0       | 0          | 1           | 0      |
//   | FLUSH      | 1     | 1       | 1          | 1           | 0      |
//   | HALT       | 0     | 0       | 0          | 1           | 1      |
//
//   - halted and state_o are the exceptions: they come from the registered state.
// - Watchdog:
//   - 8-bit consecutive-STALL counter increments each posedge with state==STALL.
//   - It clears on any other state and saturates at MAX_STALL.
//   - When it reaches MAX_STALL, stall_timeout sets and holds until rst_n.
// - resume outside HALT: no effect.
// - resume with syscall_halt_id both 1 while in HALT: go to RUN. The syscall is re-sampled next cycle.
// - Reset mid-FLUSH or mid-HALT: immediate return to the reset values above. No residual flush.
// CONFIGURATION
// - Macro STALL_CTRL_PERF_CNT_EN.
// - Defined: adds three 32-bit output ports.
//   - perf_stall_cnt, perf_flush_cnt, perf_halt_cnt.
//   - Each increments at posedge while state is STALL / FLUSH / HALT respectively.
//   - Wrap modulo 2^32; reset to 0.
// - Undefined: the ports and counters do not exist. All other behaviour is identical.
// TESTING
// - Reset release with no requests -> pc_en=1, ifid_en=1, idex_bubble=0, state_o=0.
// - nop_lock_id=1 for 1 cycle -> same cycle pc_en=0, ifid_en=0, idex_bubble=1; next cycle state_o=1, then RUN.
// - FLUSH_CYCLES=2, branch_taken_ex pulse -> ifid_flush=1 for exactly 2 cycles.
//   - nop_lock_id=1 in the 2nd cycle still yields ifid_flush=1, not a stall.
// - syscall_halt_id, branch_taken_ex, nop_lock_id all 1 in one cycle -> HALT.
//   - halted=1 from the next cycle until the cycle after a resume pulse.
// - nop_lock_id held high, MAX_STALL=4 -> stall_timeout=1 after the 4th STALL posedge.
//   - Stays 1 after the lock drops; clears only on rst_n=0.
// - With STALL_CTRL_PERF_CNT_EN: 3 stalls + 1 branch (FLUSH_CYCLES=1) + 5 HALT cycles -> counters 3/1/5.
//   - Assert rst_n=0 mid-HALT -> all counters 0, state_o=0 asynchronously.

Source files
------------

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard requests into, and PC / IF-ID / ID-EX controls out of, the pipeline stall controller.
// Purely combinational bundle; no handshake or backpressure of its own.
interface pipeline_stall_ctrl_if;
  logic       nop_lock_id;
  logic       branch_taken_ex;
  logic       syscall_halt_id;
  logic       resume;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       halted;
  logic       stall_timeout;
  logic [1:0] state_o;

  modport master (
    output nop_lock_id, branch_taken_ex, syscall_halt_id, resume,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, halted, stall_timeout, state_o
  );

  modport slave (
    input  nop_lock_id, branch_taken_ex, syscall_halt_id, resume,
    output pc_en, ifid_en, ifid_flush, idex_bubble, halted, stall_timeout, state_o
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Arbitrates halt / branch flush / load-use stall into 5-stage pipeline controls; 0-cycle (Mealy) control latency.
// Stalls are the backpressure; STALL_CTRL_PERF_CNT_EN adds STALL/FLUSH/HALT occupancy counters.
module pipeline_stall_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_STALL    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_stall_ctrl_if.slave ctl
`ifdef STALL_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt,
  output logic [31:0]          perf_halt_cnt
`endif
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0] FLUSH_LD  = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] STALL_MAX = 8'(MAX_STALL);

  logic [1:0] state, next_state;
  logic [3:0] flush_cnt, flush_cnt_nxt;
  logic [7:0] stall_cnt, stall_cnt_nxt;
  logic       stall_timeout;

  // Priority: HALT holds until resume, then syscall > branch > flush window > load-use.
  always_comb begin
    next_state    = S_RUN;
    flush_cnt_nxt = flush_cnt;
    if (state == S_HALT) begin
      next_state = ctl.resume ? S_RUN : S_HALT;
    end else if (ctl.syscall_halt_id) begin
      next_state = S_HALT;
    end else if (ctl.branch_taken_ex) begin
      next_state    = S_FLUSH;
      flush_cnt_nxt = FLUSH_LD;
    end else if (state == S_FLUSH && flush_cnt != 4'd0) begin
      next_state    = S_FLUSH;
      flush_cnt_nxt = flush_cnt - 4'd1;
    end else if (ctl.nop_lock_id) begin
      next_state = S_STALL;
    end
  end

  always_comb begin
    stall_cnt_nxt = 8'd0;
    if (state == S_STALL)
      stall_cnt_nxt = (stall_cnt < STALL_MAX) ? stall_cnt + 8'd1 : stall_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_RUN;
      flush_cnt     <= 4'd0;
      stall_cnt     <= 8'd0;
      stall_timeout <= 1'b0;
    end else begin
      state         <= next_state;
      flush_cnt     <= flush_cnt_nxt;
      stall_cnt     <= stall_cnt_nxt;
      stall_timeout <= stall_timeout | (stall_cnt_nxt == STALL_MAX);
    end
  end

  // Reset holds the pipeline frozen with a bubble in ID/EX.
  always_comb begin
    ctl.pc_en       = 1'b0;
    ctl.ifid_en     = 1'b0;
    ctl.ifid_flush  = 1'b0;
    ctl.idex_bubble = 1'b1;
    if (rst_n) begin
      case (next_state)
        S_RUN: begin
          ctl.pc_en       = 1'b1;
          ctl.ifid_en     = 1'b1;
          ctl.idex_bubble = 1'b0;
        end
        S_FLUSH: begin
          ctl.pc_en      = 1'b1;
          ctl.ifid_en    = 1'b1;
          ctl.ifid_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ctl.halted        = (state == S_HALT);
  assign ctl.state_o       = state;
  assign ctl.stall_timeout = stall_timeout;

`ifdef STALL_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
      perf_halt_cnt  <= 32'd0;
    end else begin
      if (state == S_STALL) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (state == S_FLUSH) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (state == S_HALT)  perf_halt_cnt  <= perf_halt_cnt + 32'd1;
    end
  end
`endif

endmodule
